// File: rtl/jedro_1_ifu_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch unit.
package jedro_1_ifu_pkg;

  localparam int          DATA_WIDTH        = 32;
  localparam int          FIFO_W            = 2 * DATA_WIDTH;
  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

  // Fetch FSM: idle/issuing, waiting for a live response, waiting to drop a stale one.
  typedef enum logic [1:0] {
    IFU_S_IDLE    = 2'd0,
    IFU_S_WAIT    = 2'd1,
    IFU_S_DISCARD = 2'd2
  } ifu_state_e;

  // One prefetch buffer entry: the instruction and the address it was fetched from.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch FIFO holding {addr, instr} entries; head is visible combinationally.
module jedro_1_ifu_fifo
  import jedro_1_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [FIFO_W-1:0] data_i,
  output logic [FIFO_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [FIFO_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // An empty buffer presents zeros so the decoder never sees stale words.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/jedro_1_ifu.sv
// RV32I instruction fetch unit: PC, single-outstanding memory request FSM, prefetch buffer.
module jedro_1_ifu
  import jedro_1_ifu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  imem_req_o,
  input  logic                  imem_gnt_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  jmp_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  ifu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic                  req;
  logic                  push;
  logic                  pop;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;
  logic [FIFO_W-1:0]     fifo_head;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      count_plus1;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign count_plus1     = fifo_count + CNT_W'(1);
  assign push_entry.addr  = pend_addr_q;
  assign push_entry.instr = imem_rdata_i;

  // Next-state logic: request issue with slot reservation, response routing, redirect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    req         = 1'b0;
    push        = 1'b0;

    case (state_q)
      IFU_S_IDLE: begin
        // No response is outstanding, so a free FIFO slot is enough to issue.
        req = rstn_i & ~jmp_i & ~fifo_full;
        if (req && imem_gnt_i) begin
          state_d     = IFU_S_WAIT;
          pend_addr_d = pc_q;
          pc_d        = pc_q + 32'd4;
        end
      end

      IFU_S_WAIT: begin
        if (imem_rvalid_i) begin
          if (jmp_i) begin
            // Response for the old stream arrives with the redirect: drop it.
            state_d = IFU_S_IDLE;
          end else begin
            push = 1'b1;
            // Back-to-back issue only if a slot is still free after this push.
            req  = rstn_i & (count_plus1 < DEPTH_C);
            if (req && imem_gnt_i) begin
              pend_addr_d = pc_q;
              pc_d        = pc_q + 32'd4;
            end else begin
              state_d = IFU_S_IDLE;
            end
          end
        end else if (jmp_i) begin
          state_d = IFU_S_DISCARD;
        end
      end

      IFU_S_DISCARD: begin
        if (imem_rvalid_i) state_d = IFU_S_IDLE;
      end

      default: state_d = IFU_S_IDLE;
    endcase

    if (jmp_i) pc_d = word_align(jmp_addr_i);
  end

  // State, PC and pending-address registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IFU_S_IDLE;
      pc_q        <= BOOT_ADDR;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  assign instr_valid_o = ~fifo_empty;
  assign pop           = instr_valid_o & instr_ready_i;
  assign head_entry    = fifo_head;
  assign instr_rdata_o = head_entry.instr;
  assign instr_addr_o  = head_entry.addr;

  jedro_1_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (jmp_i),
    .data_i  (push_entry),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Cycle-accurate directed bench for jedro_1_ifu: vector table plus corner-case sequences.
module tb_jedro_1_ifu;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic        imem_gnt;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic [31:0] instr_addr;

  int total = 0;
  int bad   = 0;

  jedro_1_ifu #(
    .BOOT_ADDR  (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .imem_req_o    (imem_req),
    .imem_gnt_i    (imem_gnt),
    .imem_addr_o   (imem_addr),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .jmp_i         (jmp),
    .jmp_addr_i    (jmp_addr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_rdata_o (instr_rdata),
    .instr_addr_o  (instr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs applied during the cycle, outputs expected during the same cycle.
  // mode 0: check req only; 1: req/addr/valid (+head when valid); 2: everything.
  typedef struct {
    logic        rstn, gnt, rv;
    logic [31:0] rdata;
    logic        jmp;
    logic [31:0] jaddr;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] eiaddr, edata;
    logic [1:0]  mode;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic g, input logic v, input logic [31:0] d,
                              input logic j, input logic [31:0] ja, input logic y,
                              input logic erq, input logic [31:0] ead, input logic evl,
                              input logic [31:0] eia, input logic [31:0] edt, input logic [1:0] m);
    vec_t t;
    t.rstn = r; t.gnt = g; t.rv = v; t.rdata = d; t.jmp = j; t.jaddr = ja; t.rdy = y;
    t.ereq = erq; t.eaddr = ead; t.evalid = evl; t.eiaddr = eia; t.edata = edt; t.mode = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rstn        = v.rstn;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    jmp         = v.jmp;
    jmp_addr    = v.jaddr;
    instr_ready = v.rdy;
    #1;
    chk($sformatf("%s[%0d].req", tag, idx), {31'd0, imem_req}, {31'd0, v.ereq});
    if (v.mode != 2'd0) begin
      chk($sformatf("%s[%0d].imem_addr", tag, idx), imem_addr, v.eaddr);
      chk($sformatf("%s[%0d].valid", tag, idx), {31'd0, instr_valid}, {31'd0, v.evalid});
      if (v.evalid || v.mode == 2'd2) begin
        chk($sformatf("%s[%0d].instr_addr", tag, idx), instr_addr, v.eiaddr);
        chk($sformatf("%s[%0d].instr_rdata", tag, idx), instr_rdata, v.edata);
      end
    end
    $display("%s[%0d] req=%0b addr=%h valid=%0b iaddr=%h idata=%h", tag, idx,
             imem_req, imem_addr, instr_valid, instr_addr, instr_rdata);
  endtask

  localparam int NT = 31;
  vec_t tbl [NT];

  initial begin
    rstn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    jmp = 1'b0; jmp_addr = '0; instr_ready = 1'b1;

    // Reset, streaming, stall, jump with rvalid, jump in WAIT, PC wrap, pop+jump.
    tbl[0]  = mk(0,0,0,32'h0,          0,32'h0,         1, 0,32'h0,        0,32'h0,        32'h0,        0);
    tbl[1]  = mk(0,0,0,32'h0,          0,32'h0,         1, 0,32'h0,        0,32'h0,        32'h0,        2);
    tbl[2]  = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h0,        0,32'h0,        32'h0,        1);
    tbl[3]  = mk(1,1,1,32'h1000_0000,  0,32'h0,         1, 1,32'h4,        0,32'h0,        32'h0,        1);
    tbl[4]  = mk(1,1,1,32'h1000_0004,  0,32'h0,         1, 0,32'h8,        1,32'h0,        32'h1000_0000,1);
    tbl[5]  = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h8,        1,32'h4,        32'h1000_0004,1);
    tbl[6]  = mk(1,1,1,32'h1000_0008,  0,32'h0,         1, 1,32'hC,        0,32'h0,        32'h0,        1);
    tbl[7]  = mk(1,1,1,32'h1000_000C,  0,32'h0,         1, 0,32'h10,       1,32'h8,        32'h1000_0008,1);
    tbl[8]  = mk(1,1,0,32'h0,          0,32'h0,         0, 1,32'h10,       1,32'hC,        32'h1000_000C,1);
    tbl[9]  = mk(1,1,1,32'h1000_0010,  0,32'h0,         0, 0,32'h14,       1,32'hC,        32'h1000_000C,1);
    tbl[10] = mk(1,1,0,32'h0,          0,32'h0,         0, 0,32'h14,       1,32'hC,        32'h1000_000C,1);
    tbl[11] = mk(1,1,0,32'h0,          0,32'h0,         0, 0,32'h14,       1,32'hC,        32'h1000_000C,1);
    tbl[12] = mk(1,1,0,32'h0,          0,32'h0,         1, 0,32'h14,       1,32'hC,        32'h1000_000C,1);
    tbl[13] = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h14,       1,32'h10,       32'h1000_0010,1);
    tbl[14] = mk(1,1,1,32'h1000_0014,  1,32'h203,       1, 0,32'h18,       0,32'h0,        32'h0,        1);
    tbl[15] = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h200,      0,32'h0,        32'h0,        1);
    tbl[16] = mk(1,0,1,32'h1000_0200,  0,32'h0,         1, 1,32'h204,      0,32'h0,        32'h0,        1);
    tbl[17] = mk(1,0,0,32'h0,          0,32'h0,         1, 1,32'h204,      1,32'h200,      32'h1000_0200,1);
    tbl[18] = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h204,      0,32'h0,        32'h0,        1);
    tbl[19] = mk(1,1,0,32'h0,          1,32'h100,       1, 0,32'h208,      0,32'h0,        32'h0,        1);
    tbl[20] = mk(1,1,0,32'h0,          0,32'h0,         1, 0,32'h100,      0,32'h0,        32'h0,        1);
    tbl[21] = mk(1,1,1,32'h1000_0204,  0,32'h0,         1, 0,32'h100,      0,32'h0,        32'h0,        1);
    tbl[22] = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'h100,      0,32'h0,        32'h0,        1);
    tbl[23] = mk(1,0,1,32'h1000_0100,  0,32'h0,         1, 1,32'h104,      0,32'h0,        32'h0,        1);
    tbl[24] = mk(1,0,0,32'h0,          0,32'h0,         1, 1,32'h104,      1,32'h100,      32'h1000_0100,1);
    tbl[25] = mk(1,1,0,32'h0,          1,32'hFFFF_FFFE, 1, 0,32'h104,      0,32'h0,        32'h0,        1);
    tbl[26] = mk(1,1,0,32'h0,          0,32'h0,         1, 1,32'hFFFF_FFFC,0,32'h0,        32'h0,        1);
    tbl[27] = mk(1,0,1,32'h2000_0000,  0,32'h0,         1, 1,32'h0,        0,32'h0,        32'h0,        1);
    tbl[28] = mk(1,0,0,32'h0,          0,32'h0,         0, 1,32'h0,        1,32'hFFFF_FFFC,32'h2000_0000,1);
    tbl[29] = mk(1,1,0,32'h0,          1,32'h40,        1, 0,32'h0,        1,32'hFFFF_FFFC,32'h2000_0000,1);
    tbl[30] = mk(1,0,0,32'h0,          0,32'h0,         1, 1,32'h40,       0,32'h0,        32'h0,        1);

    for (int i = 0; i < NT; i++) apply(tbl[i], "tbl", i);

    // Slow grant (3 cycles), rvalid 2 cycles after gnt, then a 10-cycle decoder stall.
    apply(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0), "gnt_delay", 0);
    apply(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,2), "gnt_delay", 1);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "gnt_delay", 2);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "gnt_delay", 3);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "gnt_delay", 4);
    apply(mk(1,1,0,32'h0,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "gnt_delay", 5);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 0,32'h4,0,32'h0,32'h0,1), "gnt_delay", 6);
    apply(mk(1,0,1,32'h1000_0000,0,32'h0,1, 1,32'h4,0,32'h0,32'h0,1), "gnt_delay", 7);
    apply(mk(1,1,0,32'h0,0,32'h0,0, 1,32'h4,1,32'h0,32'h1000_0000,1), "stall", 0);
    apply(mk(1,1,1,32'h1000_0004,0,32'h0,0, 0,32'h8,1,32'h0,32'h1000_0000,1), "stall", 1);
    for (int k = 0; k < 10; k++)
      apply(mk(1,1,0,32'h0,0,32'h0,0, 0,32'h8,1,32'h0,32'h1000_0000,1), "stall_hold", k);
    apply(mk(1,1,0,32'h0,0,32'h0,1, 0,32'h8,1,32'h0,32'h1000_0000,1), "release", 0);
    apply(mk(1,1,0,32'h0,0,32'h0,1, 1,32'h8,1,32'h4,32'h1000_0004,1), "release", 1);
    apply(mk(1,0,1,32'h1000_0008,0,32'h0,1, 1,32'hC,0,32'h0,32'h0,1), "release", 2);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 1,32'hC,1,32'h8,32'h1000_0008,1), "release", 3);

    // Reset while a request is outstanding; its late rvalid must be ignored.
    apply(mk(1,1,0,32'h0,0,32'h0,1, 1,32'hC,0,32'h0,32'h0,1), "rst_wait", 0);
    apply(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,0), "rst_wait", 1);
    apply(mk(0,0,0,32'h0,0,32'h0,1, 0,32'h0,0,32'h0,32'h0,2), "rst_wait", 2);
    apply(mk(1,0,1,32'hDEAD_BEEF,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "rst_wait", 3);
    apply(mk(1,1,0,32'h0,0,32'h0,1, 1,32'h0,0,32'h0,32'h0,1), "rst_wait", 4);
    apply(mk(1,0,1,32'h1000_0000,0,32'h0,1, 1,32'h4,0,32'h0,32'h0,1), "rst_wait", 5);
    apply(mk(1,0,0,32'h0,0,32'h0,1, 1,32'h4,1,32'h0,32'h1000_0000,1), "rst_wait", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jedro_1_ifu.md
Name: jedro_1_ifu

Overview:
Instruction fetch unit for the RV32I core. It sits directly upstream of jedro_1_decoder. It keeps the program counter and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small prefetch FIFO and presented to the decoder with a valid/ready handshake; a jump request flushes the FIFO and redirects fetch.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value after reset.
FIFO_DEPTH, 2, prefetch buffer entries; power of two, at least 2.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rstn_i  input  1  reset, synchronous, active-low.
imem_req_o  output  1  fetch request to instruction memory.
imem_gnt_i  input  1  memory accepted the request this cycle.
imem_addr_o  output  32  word-aligned fetch address; equals PC.
imem_rvalid_i  input  1  read data valid.
imem_rdata_i  input  32  instruction word.
jmp_i  input  1  redirect fetch (branch/jump/exception).
jmp_addr_i  input  32  redirect target; bits [1:0] ignored, treated as 0.
instr_valid_o  output  1  instr_rdata_o/instr_addr_o hold a valid instruction.
instr_ready_i  input  1  decoder consumes the head entry when valid and ready.
instr_rdata_o  output  32  instruction word to decoder.
instr_addr_o  output  32  address of that instruction.

Behaviour:
- Reset (rstn_i low at clock edge): PC=BOOT_ADDR; FIFO empty; FSM=S_IDLE; no request outstanding; imem_req_o=0, instr_valid_o=0, instr_rdata_o=0, instr_addr_o=0. Reset mid-transaction abandons it. A late rvalid arriving after reset is ignored.
- At most one request outstanding. Memory returns the response no earlier than 1 cycle after gnt.
- FSM states:
  - S_IDLE: imem_req_o=1 when fifo_count < FIFO_DEPTH and jmp_i=0. A handshake (req&gnt) moves to S_WAIT, latches the request address as pending_addr, and sets PC=PC+4.
  - S_WAIT: imem_req_o=0. On rvalid, push {pending_addr, rdata} and go to S_IDLE. The request may re-issue the same cycle only if FIFO space remains after the push.
  - S_DISCARD: outstanding response is stale. On rvalid, drop it and go to S_IDLE.
- Slot reservation: a request is issued only if fifo_count + outstanding < FIFO_DEPTH. The FIFO therefore never overflows, and rvalid never needs to be back-pressured.
- Output: the FIFO head drives instr_*_o. Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle leaves the count unchanged. Empty FIFO gives instr_valid_o=0. Data/addr hold stable while valid and not ready.
- Jump (jmp_i=1):
  - The FIFO is flushed next cycle, so instr_valid_o=0 the cycle after.
  - PC=jmp_addr_i & ~3.
  - If in S_WAIT, go to S_DISCARD.
  - If rvalid arrives the same cycle as jmp_i, the data is dropped and not pushed.
  - imem_req_o is forced 0 while jmp_i=1, so no request to the old PC is granted.
  - A jump while in S_DISCARD only updates PC.
  - First request to the target: the cycle after jmp_i when in S_IDLE; otherwise the cycle after the stale rvalid.
- Fetch latency: from jmp_i to instr_valid_o is 2 cycles plus memory latency (1-cycle gnt, 1-cycle rvalid: jmp at cycle 0, req/gnt at 1, rvalid at 2, valid at 3).
- PC arithmetic is 32-bit, wrapping at 32'hFFFF_FFFC + 4 = 0.
- Pop and jmp in the same cycle: the flush wins; the pop completes as a handshake but the FIFO ends empty.

Decomposition:
- jedro_1_defines.v: DATA_WIDTH, FSM state encodings (IFU_S_IDLE, IFU_S_WAIT, IFU_S_DISCARD), BOOT_ADDR default.
- Sub-module jedro_1_ifu_fifo: synchronous FIFO of {addr, instr}, width 64, depth FIFO_DEPTH.
  - Ports: push, pop, flush, count, full, empty, head data.
  - Reset and flush clear pointers and count.
- jedro_1_ifu holds the PC, FSM, request logic and slot reservation.

Test Plan:
- Reset, memory always grants, 1-cycle rvalid, instr_ready_i=1 → instr_addr_o sequence 0x0,0x4,0x8,… with matching data; imem_req_o low during reset.
- instr_ready_i=0 held for 10 cycles → exactly 2 entries (0x0,0x4) buffered, imem_req_o=0 after the second grant, outputs stable. Release → 0x0,0x4,0x8 delivered in order.
- imem_gnt_i delayed 3 cycles, rvalid 2 cycles after gnt → imem_addr_o held at 0x0 with req high until gnt; no duplicate fetch.
- jmp_i with jmp_addr_i=0x100 while in S_WAIT for 0x8 → response for 0x8 dropped; next delivered instruction has addr 0x100; FIFO flushed.
- jmp_i same cycle as rvalid, jmp_addr_i=0x203 → data dropped, PC=0x200, first imem_addr_o after the jump is 0x200.
- rstn_i low while in S_WAIT, rvalid arrives the cycle after reset release → ignored; first delivered instr_addr_o=BOOT_ADDR.
